stereo_frame_assembler: RTL
===========================

# stereo_frame_assembler

Downstream consumer of the serial audio decoder's per-channel sample stream, in the same `sclk` domain. Pairs a left sample with the following right sample into one stereo frame, rounds and saturates each 32-bit MSB-aligned sample to `OUT_WIDTH` bits, and buffers frames in a small FIFO for the next consumer. Out-of-order channel samples are discarded and counted, not propagated.

## Interface
- `OUT_WIDTH`, 24: output sample width, 8..32.
- `FIFO_DEPTH`, 4: frame FIFO entries, power of two, ≥2.
- `sclk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: decoder sample valid.
- `i_ready` out 1: sample accepted when `i_valid && i_ready`.
- `i_is_left` in 1: 1 = left, 0 = right.
- `i_audio` in 32: signed two's-complement sample, MSB-aligned.
- `o_valid` out 1: frame at FIFO head valid.
- `o_ready` in 1: consumer takes frame when `o_valid && o_ready`.
- `o_left` out OUT_WIDTH: left sample of head frame.
- `o_right` out OUT_WIDTH: right sample of head frame.
- `o_level` out $clog2(FIFO_DEPTH)+1: frames stored.
- `o_orphan_count` out 8: saturating count of discarded samples.

## Operation
- States: `WAIT_LEFT` (reset state) and `WAIT_RIGHT`.
- `WAIT_LEFT`, left accepted: round it into `left_hold`, go to `WAIT_RIGHT`.
- `WAIT_LEFT`, right accepted: discard, `o_orphan_count`++, stay.
- `WAIT_RIGHT`, right accepted: push {`left_hold`, rounded right} into the FIFO, go to `WAIT_LEFT`.
- `WAIT_RIGHT`, left accepted: the held left is an orphan. Replace `left_hold`, `o_orphan_count`++, stay.
- Rounding, with S = 32-OUT_WIDTH:
  - If S=0, pass the sample through.
  - Otherwise form a 33-bit sign-extended sum: `i_audio + (1<<(S-1))`, i.e. round half up.
  - Take bits [31:S].
  - If the input is positive and the sum's bit 31 is set, saturate to the maximum positive value, 0x7F…F.
  - Negative inputs never saturate.
- `i_ready = (state==WAIT_LEFT) || !fifo_full`.
  - Registered state only; no combinational path from `o_ready` or `i_valid`.
  - A pop in the same cycle does not raise `i_ready`.
- FIFO: simultaneous push and pop is allowed when not empty and not full. When full, push is impossible because `i_ready`=0 in `WAIT_RIGHT`.
- Pointers wrap modulo `FIFO_DEPTH`, with one extra bit to distinguish full from empty.
- `o_orphan_count` holds at 255 and clears only on reset.

## Timing
- Reset values: state `WAIT_LEFT`, `o_valid`=0, `i_ready`=1, `o_left`/`o_right`=0, `o_level`=0, `o_orphan_count`=0, `left_hold`=0.
- Reset mid-frame drops the held left and all FIFO contents immediately (asynchronous).
- Latency: right accepted on edge N into an empty FIFO gives `o_valid`=1 with data on edge N+1.
- `o_left`/`o_right` are registered FIFO-head outputs. They are stable while `o_valid && !o_ready`.
- `o_level` updates on the edge after push or pop; it is unchanged on a simultaneous push and pop.
- Orphan counter updates on the accepting edge.

## Structure
- Package `serial_audio_pkg`:
  - state enum `frame_state_t`;
  - function `round_sat(input [31:0], width)`;
  - constant `ORPHAN_MAX = 8'hFF`.
- Sub-module `audio_frame_fifo`: synchronous FIFO, width 2*OUT_WIDTH, depth `FIFO_DEPTH`, `sclk`/`reset_n`, push/pop/full/empty/level, registered head.
- Top level: FSM, hold register, rounding, orphan counter, ready logic. About 200 lines total.

## Test plan
- Pairing and rounding (OUT_WIDTH=24, `o_ready`=1): L=0x12345678, R=0x12345680 → one frame `o_left`=0x123456, `o_right`=0x123457; `o_valid` one edge after the R handshake.
- Saturation and sign: L=0x7FFFFF80, R=0xFFFFFF80 → `o_left`=0x7FFFFF, `o_right`=0x000000. Then L=0x80000000, R=0xFFFFFF7F → `o_left`=0x800000, `o_right`=0xFFFFFF.
- Orphans: sequence R(0x11111111), L(0x22222222), L(0x33333333), R(0x44444444) → one frame {0x333333, 0x444444}, `o_orphan_count`=2.
- Backpressure: `o_ready`=0, push 5 L/R pairs with FIFO_DEPTH=4 → `o_level`=4, `i_ready`=0 only in `WAIT_RIGHT`, 5th right held in `i_audio`. Then `o_ready`=1 → frames emerge in order, 5th frame accepted, none lost.
- Simultaneous push and pop at `o_level`=2 → `o_level` stays 2, head advances by one frame.
- Reset mid-operation: assert `reset_n`=0 while in `WAIT_RIGHT` with 3 frames stored → all outputs at reset values immediately. After release, the next R is counted as an orphan (`o_orphan_count`=1).

Source files
------------

// File: rtl/serial_audio_pkg.sv
// Shared types and helpers for the stereo frame assembler: pairing states,
// the orphan counter ceiling and the round-half-up / saturate function.
package serial_audio_pkg;

    localparam int unsigned SAMPLE_W   = 32;
    localparam logic [7:0]  ORPHAN_MAX = 8'hFF;

    typedef enum logic {
        WAIT_LEFT  = 1'b0,
        WAIT_RIGHT = 1'b1
    } frame_state_t;

    // Round an MSB-aligned 32-bit sample to 'width' bits (result right-aligned).
    // Only positive inputs can carry into bit 31, so only they saturate.
    function automatic logic [SAMPLE_W-1:0] round_sat(input logic [SAMPLE_W-1:0] sample,
                                                      input int unsigned         width);
        logic [SAMPLE_W:0]   sum;
        logic [SAMPLE_W-1:0] res;
        int unsigned         shift;
        shift = SAMPLE_W - width;
        if (shift == 0) return sample;
        sum = {sample[SAMPLE_W-1], sample} + ((SAMPLE_W+1)'(1) << (shift - 1));
        res = sum[SAMPLE_W-1:0] >> shift;
        if (!sample[SAMPLE_W-1] && sum[SAMPLE_W-1])
            res = (SAMPLE_W'(1) << (width - 1)) - SAMPLE_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/stereo_frame_assembler_if.sv
// Sample-in / frame-out handshake bundle of the stereo frame assembler.
// The slave modport is the assembler side, master is its environment.
interface stereo_frame_assembler_if #(
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 i_valid;
    logic                 i_ready;
    logic                 i_is_left;
    logic [31:0]          i_audio;
    logic                 o_valid;
    logic                 o_ready;
    logic [OUT_WIDTH-1:0] o_left;
    logic [OUT_WIDTH-1:0] o_right;
    logic [LEVEL_W-1:0]   o_level;
    logic [7:0]           o_orphan_count;

    modport slave (
        input  i_valid, i_is_left, i_audio, o_ready,
        output i_ready, o_valid, o_left, o_right, o_level, o_orphan_count
    );

    modport master (
        output i_valid, i_is_left, i_audio, o_ready,
        input  i_ready, o_valid, o_left, o_right, o_level, o_orphan_count
    );

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with a registered head word and registered
// full/empty/level flags; pointers carry one wrap bit.
module audio_frame_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sclk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, level_q, level_d, remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q, do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next pointers and the word that becomes the head after this edge.
    always_comb begin
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        level_d = wr_d - rd_d;
        remain  = level_q - PW'(do_pop);
        head_d  = head_q;
        if (remain != '0)
            head_d = mem_q[rd_d[AW-1:0]];
        else if (do_push)
            head_d = data_i;
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
            full_q  <= (level_d == PW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
    assign head_o  = head_q;

endmodule

// File: rtl/stereo_frame_assembler.sv
// Pairs a left sample with the following right sample, rounds/saturates both
// to OUT_WIDTH and queues the stereo frame; out-of-order samples are counted.
module stereo_frame_assembler
    import serial_audio_pkg::*;
#(
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     sclk,
    input  logic                     reset_n,
    stereo_frame_assembler_if.slave  bus
);
    localparam int unsigned FW = 2 * OUT_WIDTH;

    frame_state_t           state_q, state_d;
    logic [OUT_WIDTH-1:0]   hold_q, hold_d, rounded;
    logic [7:0]             orphan_q, orphan_d;
    logic                   orphan_hit, accept, push, pop;
    logic                   fifo_full, fifo_empty;
    logic [FW-1:0]          fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    assign rounded = OUT_WIDTH'(round_sat(bus.i_audio, OUT_WIDTH));

    // Ready depends on registered state only, so a same-cycle pop cannot raise it.
    assign bus.i_ready = (state_q == WAIT_LEFT) || !fifo_full;
    assign accept      = bus.i_valid && bus.i_ready;
    assign push        = accept && !bus.i_is_left && (state_q == WAIT_RIGHT);
    assign pop         = bus.o_ready && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        orphan_hit = 1'b0;
        if (accept) begin
            case (state_q)
                WAIT_LEFT: begin
                    if (bus.i_is_left) begin
                        hold_d  = rounded;
                        state_d = WAIT_RIGHT;
                    end else begin
                        orphan_hit = 1'b1;
                    end
                end
                WAIT_RIGHT: begin
                    if (bus.i_is_left) begin
                        hold_d     = rounded;
                        orphan_hit = 1'b1;
                    end else begin
                        state_d = WAIT_LEFT;
                    end
                end
                default: state_d = WAIT_LEFT;
            endcase
        end
        orphan_d = (orphan_hit && (orphan_q != ORPHAN_MAX)) ? orphan_q + 8'd1 : orphan_q;
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_LEFT;
            hold_q   <= '0;
            orphan_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            orphan_q <= orphan_d;
        end
    end

    audio_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  ({hold_q, rounded}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (fifo_head)
    );

    assign bus.o_valid        = !fifo_empty;
    assign bus.o_left         = fifo_head[FW-1:OUT_WIDTH];
    assign bus.o_right        = fifo_head[OUT_WIDTH-1:0];
    assign bus.o_level        = fifo_level;
    assign bus.o_orphan_count = orphan_q;

endmodule
